// File: rtl/img_pkg.sv
// Shared definitions for the image streaming blocks.
package img_pkg;

  // Frame streamer FSM states.
  typedef enum logic [2:0] {
    StIdle,
    StHdr0,
    StHdr1,
    StFetch,
    StWait,
    StSend,
    StTrl,
    StFin
  } state_t;

  // Default two-byte frame header, sent MSB byte first.
  localparam logic [15:0] SYNC_DEFAULT = 16'hA55A;

  // Whole bytes needed to carry one pixel of the given width.
  function automatic int unsigned bytes_per_pixel(input int unsigned pix_w);
    return (pix_w + 7) / 8;
  endfunction

endpackage

// File: rtl/frame_streamer.sv
// Streams one image frame from a pixel FIFO to a byte-wide UART:
// two header bytes, every pixel MSB byte first, then a mod-256 payload checksum.
module frame_streamer
  import img_pkg::*;
#(
  parameter int unsigned IMG_W = 640,
  parameter int unsigned IMG_H = 960,
  parameter int unsigned PIX_W = 8,
  parameter logic [15:0] SYNC  = SYNC_DEFAULT
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [PIX_W-1:0] fifo_dout,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  output logic [7:0]       uart_data,
  output logic             uart_valid,
  input  logic             uart_ready,
  output logic             busy,
  output logic             done,
  output logic [31:0]      pixel_count,
  output logic [31:0]      cycle_count
);

  localparam int unsigned BPP  = bytes_per_pixel(PIX_W);
  localparam int unsigned SW   = 8 * BPP;
  localparam int unsigned IDXW = (BPP > 1) ? $clog2(BPP) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(BPP - 1);
  localparam logic [31:0]     NPIX     = 32'(IMG_W * IMG_H);

  state_t          state_q, state_d;
  logic [SW-1:0]   shift_q;
  logic [IDXW-1:0] byte_idx_q;
  logic [31:0]     pix_cnt_q;
  logic [31:0]     cyc_cnt_q;
  logic [7:0]      csum_q;

  logic xfer;
  logic start_ok;
  logic last_byte;
  logic frame_end;

  assign xfer      = uart_valid & uart_ready;
  assign start_ok  = start & ((state_q == StIdle) | (state_q == StFin));
  assign last_byte = (byte_idx_q == LAST_IDX);
  assign frame_end = ((pix_cnt_q + 32'd1) == NPIX);

  assign pixel_count = pix_cnt_q;
  assign cycle_count = cyc_cnt_q;

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; header, payload and trailer bytes advance only on a transfer.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StFin: if (start) state_d = StHdr0;
      StHdr0:        if (xfer) state_d = StHdr1;
      StHdr1:        if (xfer) state_d = StFetch;
      StFetch:       if (!fifo_empty) state_d = StWait;
      StWait:        state_d = StSend;
      StSend:        if (xfer && last_byte) state_d = frame_end ? StTrl : StFetch;
      StTrl:         if (xfer) state_d = StFin;
      default:       state_d = StIdle;
    endcase
  end

  // Output decode from the current state.
  always_comb begin
    fifo_rd_en = 1'b0;
    uart_valid = 1'b0;
    uart_data  = 8'h00;
    busy       = 1'b1;
    done       = 1'b0;
    unique case (state_q)
      StIdle:  busy = 1'b0;
      StHdr0:  begin uart_valid = 1'b1; uart_data = SYNC[15:8]; end
      StHdr1:  begin uart_valid = 1'b1; uart_data = SYNC[7:0];  end
      StFetch: fifo_rd_en = ~fifo_empty;
      StWait:  ;
      StSend:  begin uart_valid = 1'b1; uart_data = shift_q[SW-1 -: 8]; end
      StTrl:   begin uart_valid = 1'b1; uart_data = csum_q; end
      StFin:   begin busy = 1'b0; done = 1'b1; end
      default: busy = 1'b0;
    endcase
  end

  // Pixel shifter, byte index, checksum and frame counters.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shift_q    <= '0;
      byte_idx_q <= '0;
      pix_cnt_q  <= '0;
      cyc_cnt_q  <= '0;
      csum_q     <= '0;
    end else if (start_ok) begin
      byte_idx_q <= '0;
      pix_cnt_q  <= '0;
      cyc_cnt_q  <= '0;
      csum_q     <= '0;
    end else begin
      if (busy && (cyc_cnt_q != 32'hFFFF_FFFF)) begin
        cyc_cnt_q <= cyc_cnt_q + 32'd1;
      end
      // FIFO data is valid the cycle after the pop, i.e. while in StWait.
      if (state_q == StWait) begin
        shift_q    <= SW'(fifo_dout);
        byte_idx_q <= '0;
      end
      if ((state_q == StSend) && xfer) begin
        shift_q <= shift_q << 8;
        csum_q  <= csum_q + uart_data;
        if (last_byte) begin
          byte_idx_q <= '0;
          pix_cnt_q  <= pix_cnt_q + 32'd1;
        end else begin
          byte_idx_q <= byte_idx_q + IDXW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_frame_streamer.sv
// Self-checking bench for frame_streamer: a 4x2 8-bit frame instance and a
// single-pixel 12-bit instance, with a byte scoreboard per instance.
module tb_frame_streamer;

  typedef struct {
    logic [7:0] pix;
    logic [7:0] exp_byte;
  } vec_t;

  localparam logic [7:0] EXP_CSUM = 8'h24;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [7:0]  fifo_dout;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [7:0]  uart_data;
  logic        uart_valid;
  logic        uart_ready;
  logic        busy;
  logic        done;
  logic [31:0] pixel_count;
  logic [31:0] cycle_count;

  logic        start2;
  logic [11:0] fifo2_dout;
  logic        fifo2_empty;
  logic        fifo2_rd_en;
  logic [7:0]  uart2_data;
  logic        uart2_valid;
  logic        uart2_ready;
  logic        busy2;
  logic        done2;
  logic [31:0] pixel_count2;
  logic [31:0] cycle_count2;

  int checks = 0;
  int errors = 0;

  logic [7:0] sb1[$];
  logic [7:0] sb2[$];
  vec_t       vecs[8];

  logic [7:0] mem[64];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  logic       force_empty;
  logic       flush;

  logic       held1_pending;
  logic [7:0] held1_data;

  always #5 clk = ~clk;

  assign fifo_empty  = force_empty || (rd_ptr == wr_ptr);
  assign fifo2_dout  = 12'hABC;
  assign fifo2_empty = 1'b0;
  assign uart2_ready = 1'b1;

  // FIFO model: read data appears the cycle after the pop.
  always @(posedge clk) begin
    if (flush) begin
      rd_ptr <= wr_ptr;
    end else if (fifo_rd_en) begin
      fifo_dout <= mem[rd_ptr % 64];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  frame_streamer #(
    .IMG_W(4),
    .IMG_H(2),
    .PIX_W(8)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .fifo_dout  (fifo_dout),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .uart_data  (uart_data),
    .uart_valid (uart_valid),
    .uart_ready (uart_ready),
    .busy       (busy),
    .done       (done),
    .pixel_count(pixel_count),
    .cycle_count(cycle_count)
  );

  frame_streamer #(
    .IMG_W(1),
    .IMG_H(1),
    .PIX_W(12)
  ) dut2 (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start2),
    .fifo_dout  (fifo2_dout),
    .fifo_empty (fifo2_empty),
    .fifo_rd_en (fifo2_rd_en),
    .uart_data  (uart2_data),
    .uart_valid (uart2_valid),
    .uart_ready (uart2_ready),
    .busy       (busy2),
    .done       (done2),
    .pixel_count(pixel_count2),
    .cycle_count(cycle_count2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Byte monitors, sampled on the falling edge.
  task automatic mon1();
    if (uart_valid) check("rd_en_while_valid", 32'(fifo_rd_en), 32'd0);
    if (held1_pending && uart_valid) check("data_stable", 32'(uart_data), 32'(held1_data));
    if (uart_valid && uart_ready) begin
      if (sb1.size() == 0) begin
        check("unexpected_byte", 32'(uart_data), 32'hFFFF_FFFF);
      end else begin
        check("byte", 32'(uart_data), 32'(sb1.pop_front()));
      end
      held1_pending = 1'b0;
    end else begin
      held1_pending = uart_valid;
      held1_data    = uart_data;
    end
  endtask

  task automatic mon2();
    if (uart2_valid) check("rd_en2_while_valid", 32'(fifo2_rd_en), 32'd0);
    if (uart2_valid && uart2_ready) begin
      if (sb2.size() == 0) begin
        check("unexpected_byte2", 32'(uart2_data), 32'hFFFF_FFFF);
      end else begin
        check("byte2", 32'(uart2_data), 32'(sb2.pop_front()));
      end
    end
  endtask

  // One clock: monitor at negedge, then return 1 time unit after posedge.
  task automatic tick();
    @(negedge clk);
    mon1();
    mon2();
    @(posedge clk);
    #1;
  endtask

  task automatic load_frame();
    sb1.push_back(8'hA5);
    sb1.push_back(8'h5A);
    for (int i = 0; i < 8; i++) begin
      mem[wr_ptr % 64] = vecs[i].pix;
      wr_ptr++;
      sb1.push_back(vecs[i].exp_byte);
    end
    sb1.push_back(EXP_CSUM);
  endtask

  task automatic start_frame(input string name);
    start = 1'b1;
    tick();
    start = 1'b0;
    check({name, "_valid"}, 32'(uart_valid), 32'd1);
    check({name, "_hdr0"}, 32'(uart_data), 32'hA5);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 300) begin
      tick();
      n++;
    end
    check({name, "_done"}, 32'(done), 32'd1);
  endtask

  task automatic wait_pixels(input logic [31:0] target, input string name);
    int n = 0;
    while (pixel_count != target && n < 300) begin
      tick();
      n++;
    end
    check(name, pixel_count, target);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_rd_en"}, 32'(fifo_rd_en), 32'd0);
    check({name, "_valid"}, 32'(uart_valid), 32'd0);
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_done"}, 32'(done), 32'd0);
    check({name, "_data"}, 32'(uart_data), 32'd0);
    check({name, "_pix"}, pixel_count, 32'd0);
    check({name, "_cyc"}, cycle_count, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      vecs[i].pix      = 8'(i + 1);
      vecs[i].exp_byte = 8'(i + 1);
    end
    rstn          = 1'b0;
    start         = 1'b0;
    start2        = 1'b0;
    uart_ready    = 1'b1;
    force_empty   = 1'b0;
    flush         = 1'b0;
    held1_pending = 1'b0;
    held1_data    = 8'h00;

    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rstn = 1'b1;
    tick();

    // Frame 1: plain 4x2 frame.
    load_frame();
    start_frame("f1");
    wait_done("f1");
    check("f1_pix", pixel_count, 32'd8);
    check("f1_cyc", cycle_count, 32'd27);
    check("f1_busy", 32'(busy), 32'd0);
    check("f1_sb_empty", 32'(sb1.size()), 32'd0);

    // Frame 2: restart from FIN, ignored start while busy, backpressure on byte 03.
    load_frame();
    start_frame("f2");
    check("f2_done_clr", 32'(done), 32'd0);
    check("f2_pix_zero", pixel_count, 32'd0);
    check("f2_cyc_zero", cycle_count, 32'd0);
    repeat (3) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 0; n < 100 && !(uart_valid && uart_data == 8'h03); n++) tick();
    check("f2_byte03_seen", 32'(uart_data), 32'h03);
    uart_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("f2_stall_data", 32'(uart_data), 32'h03);
      check("f2_stall_rd_en", 32'(fifo_rd_en), 32'd0);
    end
    uart_ready = 1'b1;
    wait_done("f2");
    check("f2_pix", pixel_count, 32'd8);
    check("f2_cyc", cycle_count, 32'd32);
    check("f2_sb_empty", 32'(sb1.size()), 32'd0);

    // Frame 3: FIFO empty for 10 cycles after pixel 4.
    load_frame();
    start_frame("f3");
    wait_pixels(32'd4, "f3_reach4");
    force_empty = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("f3_stall_rd_en", 32'(fifo_rd_en), 32'd0);
    end
    force_empty = 1'b0;
    wait_done("f3");
    check("f3_pix", pixel_count, 32'd8);
    check("f3_cyc", cycle_count, 32'd37);
    check("f3_sb_empty", 32'(sb1.size()), 32'd0);

    // Frame 4: reset after 3 pixels, then a fresh frame.
    load_frame();
    start_frame("f4");
    wait_pixels(32'd3, "f4_reach3");
    rstn = 1'b0;
    #1;
    check_reset_outputs("midreset");
    sb1.delete();
    held1_pending = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    rstn  = 1'b1;
    tick();
    load_frame();
    start_frame("f5");
    wait_done("f5");
    check("f5_pix", pixel_count, 32'd8);
    check("f5_cyc", cycle_count, 32'd27);
    check("f5_sb_empty", 32'(sb1.size()), 32'd0);

    // 12-bit single-pixel frame.
    sb2.push_back(8'hA5);
    sb2.push_back(8'h5A);
    sb2.push_back(8'h0A);
    sb2.push_back(8'hBC);
    sb2.push_back(8'hC6);
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    check("p12_valid", 32'(uart2_valid), 32'd1);
    check("p12_hdr0", 32'(uart2_data), 32'hA5);
    for (int n = 0; n < 100 && !done2; n++) tick();
    check("p12_done", 32'(done2), 32'd1);
    check("p12_pix", pixel_count2, 32'd1);
    check("p12_cyc", cycle_count2, 32'd7);
    check("p12_busy", 32'(busy2), 32'd0);
    check("p12_sb_empty", 32'(sb2.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
